// File: rtl/exe_div_seq_pkg.sv
// exe_div_seq_pkg: op/state encodings and default width for the sequential divider
package exe_div_seq_pkg;
  localparam int DIV_XLEN = 32;
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_MOD  = 2'b01;
  localparam logic [1:0] DIV_OP_DIVU = 2'b10;
  localparam logic [1:0] DIV_OP_MODU = 2'b11;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_e;
endpackage

// File: rtl/exe_div_seq_div_step.sv
// div_step: one combinational restoring-division iteration
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         dvd_msb,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);
  logic [W:0] sh, diff;
  assign sh       = {rem, dvd_msb};
  assign diff     = sh - {1'b0, dvs};
  assign q_bit    = ~diff[W];
  assign rem_next = q_bit ? diff[W-1:0] : sh[W-1:0];
endmodule

// File: rtl/exe_div_seq.sv
// exe_div_seq: multi-cycle radix-2 restoring divider sequencer for the EXE stage
module exe_div_seq
  import exe_div_seq_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            req_cancel,
  input  logic            out_accept,
  output logic            busy,
  output logic            res_valid,
  output logic [XLEN-1:0] res_data
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] rem_q, dvd_q, dvs_q, res_q, rem_nx, q_fin, abs1, abs2;
  logic mod_q, neg_q_q, neg_r_q, q_bit, start, last, is_sgn, s1n, s2n, is_mod;
  assign is_sgn = req_op == DIV_OP_DIV || req_op == DIV_OP_MOD;
  assign is_mod = req_op == DIV_OP_MOD || req_op == DIV_OP_MODU;
  assign s1n    = is_sgn & req_src1[XLEN-1];
  assign s2n    = is_sgn & req_src2[XLEN-1];
  assign abs1   = s1n ? -req_src1 : req_src1;
  assign abs2   = s2n ? -req_src2 : req_src2;
  assign start  = state_q == S_IDLE && req_valid && !req_cancel;
  assign last   = state_q == S_BUSY && cnt_q == CNT_W'(XLEN - 1);
  assign q_fin  = {dvd_q[XLEN-2:0], q_bit};
  div_step #(.W(XLEN)) u_step (
    .rem(rem_q), .dvd_msb(dvd_q[XLEN-1]), .dvs(dvs_q),
    .rem_next(rem_nx), .q_bit(q_bit)
  );
  always_ff @(posedge clk) state_q <= !resetn ? S_IDLE : state_d;
  always_comb begin
    state_d = req_cancel ? S_IDLE :
              state_q == S_IDLE ? (req_valid ? S_BUSY : S_IDLE) :
              state_q == S_BUSY ? (last ? S_DONE : S_BUSY) :
              (out_accept ? S_IDLE : S_DONE);
  end
  always_comb begin
    busy      = state_q != S_IDLE;
    res_valid = state_q == S_DONE;
    res_data  = res_q;
  end
  // Quotient dvd_q shifts out dividend bits and shifts in quotient bits
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      mod_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (start) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= abs1;
      dvs_q   <= abs2;
      mod_q   <= is_mod;
      neg_q_q <= (s1n ^ s2n) && |req_src2;
      neg_r_q <= s1n;
    end else if (state_q == S_BUSY && !req_cancel) begin
      cnt_q <= cnt_q + 1'b1;
      rem_q <= rem_nx;
      dvd_q <= q_fin;
      if (last) res_q <= mod_q ? (neg_r_q ? -rem_nx : rem_nx) : (neg_q_q ? -q_fin : q_fin);
    end
  end
endmodule
